// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
// Revision : 1.0
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, den_s, den_u, q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic [31:0] res_hi, res_lo;
   logic        res_we;

   // Signed divide runs on magnitudes; this also yields 0x80000000/-1 = 0x80000000 r 0.
   always_comb begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
      b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
      den_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
      q_mag  = a_mag / den_s;
      r_mag  = a_mag % den_s;
      q_s    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
      r_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
      q_u    = a_q / den_u;
      r_u    = a_q % den_u;

      res_hi = hi_q;
      res_lo = lo_q;
      res_we = 1'b0;
      case (op_q)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
         OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = (b_q != 32'd0); end
         OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = (b_q != 32'd0); end
         default:  ;
      endcase
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (reset) begin
         busy_d = 1'b0;
         cnt_d  = '0;
         op_d   = OP_NONE;
         a_d    = 32'd0;
         b_d    = 32'd0;
         hi_d   = 32'd0;
         lo_d   = 32'd0;
      end else if (cancel) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            busy_d = 1'b0;
            if (res_we) begin
               hi_d = res_hi;
               lo_d = res_lo;
            end
         end
      end else if (start) begin
         case (md_op)
            OP_MULT, OP_MULTU: begin
               op_d   = md_op;
               a_d    = a;
               b_d    = b;
               cnt_d  = MULT_LOAD;
               busy_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               op_d   = md_op;
               a_d    = a;
               b_d    = b;
               cnt_d  = DIV_LOAD;
               busy_d = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
   end

   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : directed vector bench for md_unit (table plus corner sequences)
// Revision : 1.0
// ============================================================================
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        cancel = 1'b0;
   logic        busy;
   logic [31:0] hi_out, lo_out;

   int errors = 0;
   int checks = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic cx);
      @(negedge clk);
      start  = 1'b1;
      md_op  = op;
      a      = aa;
      b      = bb;
      cancel = cx;
      @(negedge clk);
      start  = 1'b0;
      md_op  = 3'd0;
      cancel = 1'b0;
   endtask

   // Entered on the negedge just after the start edge. poke_kind: 1 DIV start,
   // 2 cancel, 3 reset, 4 operand change; applied at busy cycle poke_cyc.
   task automatic measure(input string name, input int exp_cyc, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int poke_cyc, input int poke_kind);
      int          n;
      logic        held;
      logic [31:0] p_hi, p_lo;
      n    = 0;
      held = 1'b1;
      p_hi = hi_out;
      p_lo = lo_out;
      while (busy === 1'b1 && n < 60) begin
         n++;
         if (hi_out !== p_hi || lo_out !== p_lo) held = 1'b0;
         start  = 1'b0;
         cancel = 1'b0;
         reset  = 1'b0;
         md_op  = 3'd0;
         if (n == poke_cyc) begin
            case (poke_kind)
               1: begin start = 1'b1; md_op = 3'd3; a = 32'd9; b = 32'd2; end
               2: cancel = 1'b1;
               3: reset = 1'b1;
               4: begin a = 32'd0; b = 32'd0; end
               default: ;
            endcase
         end
         @(negedge clk);
      end
      start  = 1'b0;
      cancel = 1'b0;
      reset  = 1'b0;
      md_op  = 3'd0;
      chk({name, " busy_cycles"}, 32'(n), 32'(exp_cyc));
      chk({name, " hilo_held"}, {31'd0, held}, 32'd1);
      chk({name, " hi"}, hi_out, exp_hi);
      chk({name, " lo"}, lo_out, exp_lo);
   endtask

   initial begin
      vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
      vecs[3]  = '{3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14};
      vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[5]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
      vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[7]  = '{3'd4, 32'hFFFFFFFF, 32'd10,       10, 32'd5,        32'h19999999};
      vecs[8]  = '{3'd5, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h19999999};
      vecs[9]  = '{3'd6, 32'hCAFEBABE, 32'd0,        0,  32'h12345678, 32'hCAFEBABE};
      vecs[10] = '{3'd3, 32'd5,        32'd0,        10, 32'h12345678, 32'hCAFEBABE};
      vecs[11] = '{3'd4, 32'hFFFFFFFF, 32'd0,        10, 32'h12345678, 32'hCAFEBABE};
      vecs[12] = '{3'd0, 32'd1,        32'd1,        0,  32'h12345678, 32'hCAFEBABE};
      vecs[13] = '{3'd7, 32'd1,        32'd1,        0,  32'h12345678, 32'hCAFEBABE};
      vecs[14] = '{3'd3, 32'hFFFFFF9C, 32'd7,        10, 32'hFFFFFFFE, 32'hFFFFFFF2};

      repeat (3) @(negedge clk);
      chk("reset hi", hi_out, 32'd0);
      chk("reset lo", lo_out, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);

      // Start presented on the very first edge after reset drops.
      reset = 1'b0;
      start = 1'b1;
      md_op = 3'd1;
      a     = 32'd3;
      b     = 32'd4;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd0;
      measure("first_after_reset", 5, 32'd0, 32'd12, 0, 0);

      for (int i = 0; i < 15; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         measure($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].hi, vecs[i].lo, 0, 0);
      end

      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      measure("ignored_start", 5, 32'hFFFFFFFE, 32'h00000001, 2, 1);

      issue(3'd1, 32'd3, 32'd4, 1'b0);
      measure("cancel_mid", 3, 32'hFFFFFFFE, 32'h00000001, 3, 2);

      issue(3'd1, 32'd3, 32'd4, 1'b0);
      measure("reset_mid", 3, 32'd0, 32'd0, 3, 3);

      issue(3'd2, 32'd2, 32'd3, 1'b0);
      measure("cancel_at_done", 5, 32'd0, 32'd0, 5, 2);

      issue(3'd1, 32'd3, 32'd4, 1'b1);
      measure("cancel_with_start", 0, 32'd0, 32'd0, 0, 0);

      issue(3'd5, 32'hA5A5A5A5, 32'd0, 1'b1);
      measure("cancel_with_mthi", 0, 32'd0, 32'd0, 0, 0);

      issue(3'd1, 32'hFFFFFFFF, 32'd7, 1'b0);
      measure("operand_change", 5, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for DIV/DIVU.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  issue strobe, sampled on the rising edge.
REQ-006 md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
REQ-007 a  input  32  operand rs (dividend, multiplicand, or MTHI/MTLO source).
REQ-008 b  input  32  operand rt (divisor, multiplier).
REQ-009 cancel  input  1  flush from the pipeline controller; aborts the pending operation.
REQ-010 busy  output  1  a multi-cycle operation is in flight (registered).
REQ-011 hi_out  output  32  HI register value (registered).
REQ-012 lo_out  output  32  LO register value (registered).

Function
REQ-013 start=1 with op MULT/MULTU/DIV/DIVU while busy=0 and cancel=0: at that edge, latch a, b and op; load the counter with MULT_CYCLES or DIV_CYCLES; set busy=1.
REQ-014 Counter SHALL decrement by 1 on each subsequent edge; busy SHALL stay high for exactly N consecutive cycles after the start edge.
REQ-015 On the edge where the counter reaches 0: busy<=0 and HI/LO<=result, in the same edge; HI/LO SHALL NOT change at any earlier point.
REQ-016 MULT: {HI,LO} = signed 32x32 -> 64-bit product of the latched operands.
REQ-017 MULTU: {HI,LO} = unsigned 32x32 -> 64-bit product.
REQ-018 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-019 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-020 DIV/DIVU with latched b=0: full busy duration SHALL still elapse; HI and LO SHALL remain unchanged.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-022 start=1 with MTHI/MTLO while busy=0 and cancel=0: HI (or LO) <= a at that edge; busy stays 0 (single-cycle).
REQ-023 start=1 while busy=1: ignored for every op; the in-flight operation, operands and counter are unaffected.
REQ-024 start=1 with op NONE or 7: no state change.
REQ-025 cancel=1: at that edge busy<=0, counter<=0, pending result discarded; HI/LO unchanged.
REQ-026 cancel=1 and start=1 on the same edge: cancel wins and the start is dropped.
REQ-027 cancel=1 on the same edge the counter reaches 0: cancel wins and HI/LO are not updated.
REQ-028 Operands SHALL be taken only from the latched copies; changes on a/b while busy=1 SHALL have no effect.
REQ-029 The pipeline controller is responsible for stalling on busy|start for MF/MT/MD instructions; the block SHALL NOT depend on that stall for correctness under REQ-023.

Reset
REQ-030 reset=1 at an edge: HI=0, LO=0, busy=0, counter=0, latched op=NONE, latched operands=0.
REQ-031 Reset SHALL take priority over cancel and start; an operation in flight SHALL be aborted without writing HI/LO.
REQ-032 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-033 Signed multiply: MULT, a=0xFFFFFFFE (-2), b=3.
- busy=1 for exactly 5 cycles.
- Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 Unsigned and signed divide.
- DIVU, a=100, b=7 -> after 10 busy cycles, LO=14, HI=2.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 Move then divide by zero.
- MTHI a=0x12345678 -> hi_out=0x12345678 next cycle, busy stays 0.
- Then DIV with b=0 -> HI/LO unchanged after 10 cycles.
REQ-036 Ignored start: MULTU 0xFFFFFFFF x 0xFFFFFFFF issued, then at busy cycle 2 a DIV start is applied.
- The DIV is ignored.
- After 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 Abort cases: issue MULT 3x4.
- cancel at busy cycle 3 -> busy=0 next cycle, HI/LO keep prior values.
- Repeat with reset at busy cycle 3 -> HI=LO=0, busy=0.
REQ-038 Boundary at completion.
- cancel coinciding with the counter reaching 0 -> no HI/LO write.
- DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
